// File: rtl/rs16_8_encoder.sv
// Purpose : streaming systematic RS(16,8) encoder over GF(2^8), field poly 0x11d.
// Latency : 1 cycle from accepted message symbol to m_data; parity follows the 8th data symbol.
// Backpressure: m_ready low holds the output register and stalls both input acceptance and the LFSR.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   s_valid/s_ready/s_data    message symbols in, highest-degree coefficient first
//   m_valid/m_ready/m_data    codeword symbols out (8 data then 8 parity)
//   m_parity, m_last          m_data is a parity symbol / is codeword position 15
module rs16_8_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_parity,
    output logic       m_last
);

    // Low byte of the field polynomial x^8+x^4+x^3+x^2+1; x^8 is implied.
    localparam logic [7:0] POLY_LO = 8'h1d;

    // Generator coefficients g7..g0 of prod_{i=0..7}(x + alpha^i); GEN[i] = gi.
    localparam logic [7:0][7:0] GEN = {8'hff, 8'h0b, 8'h51, 8'h36,
                                       8'hef, 8'had, 8'hc8, 8'h18};

    typedef enum logic {
        ST_DATA,
        ST_PARITY
    } state_e;

    // Shift-and-add GF(2^8) multiply; with a constant operand this collapses to an XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] bb;
        p  = 8'h00;
        x  = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) begin
                p = p ^ x;
            end
            bb = bb >> 1;
            x  = {x[6:0], 1'b0} ^ (x[7] ? POLY_LO : 8'h00);
        end
        return p;
    endfunction

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0][7:0] r_q, r_d;
    logic            m_valid_q, m_valid_d;
    logic [7:0]      m_data_q, m_data_d;
    logic            m_parity_q, m_parity_d;
    logic            m_last_q, m_last_d;

    logic            out_free;
    logic [7:0]      fb;
    logic [7:0][7:0] fb_prod;

    assign out_free = !m_valid_q || m_ready;
    assign fb       = s_data ^ r_q[7];

    for (genvar gi = 0; gi < 8; gi++) begin : g_fb_mul
        assign fb_prod[gi] = gf_mul(GEN[gi], fb);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        m_data_d   = m_data_q;
        m_parity_d = m_parity_q;
        m_last_d   = m_last_q;
        // An output slot that drains with nothing new behind it goes empty.
        m_valid_d  = out_free ? 1'b0 : m_valid_q;
        s_ready    = 1'b0;

        case (state_q)
            ST_DATA: begin
                s_ready = out_free;
                if (s_valid && out_free) begin
                    r_d        = {r_q[6:0] ^ fb_prod[7:1], fb_prod[0]};
                    m_data_d   = s_data;
                    m_parity_d = 1'b0;
                    m_last_d   = 1'b0;
                    m_valid_d  = 1'b1;
                    cnt_d      = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (out_free) begin
                    // Zero-feedback shift drains the remainder; after 8 shifts r is all-zero,
                    // which leaves the LFSR ready for the next codeword without a clear.
                    r_d        = {r_q[6:0], 8'h00};
                    m_data_d   = r_q[7];
                    m_parity_d = 1'b1;
                    m_last_d   = (cnt_q == 3'd7);
                    m_valid_d  = 1'b1;
                    cnt_d      = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = ST_DATA;
                    end
                end
            end
            default: begin
                state_d = ST_DATA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_DATA;
            cnt_q      <= 3'd0;
            r_q        <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= 8'h00;
            m_parity_q <= 1'b0;
            m_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            r_q        <= r_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_parity_q <= m_parity_d;
            m_last_q   <= m_last_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_parity = m_parity_q;
    assign m_last   = m_last_q;

endmodule
